// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage store issuer and the WB load extractor:
// access size codes and the store FSM state encodings.
package mem_access_pkg;

  // Bus size codes (data_size) shared by load and store paths.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Store FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Map the pipeline access type (00 byte, 01 half, 1x word) to a bus size code.
  function automatic logic [1:0] size_of(input logic [1:0] mem_type);
    return mem_type[1] ? SZ_WORD : (mem_type[0] ? SZ_HALF : SZ_BYTE);
  endfunction

  // True when an access of the given size cannot start at this byte offset.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_HALF) ? addr_lo[0] :
           (size == SZ_WORD) ? (addr_lo != 2'b00) : 1'b0;
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational lane builder: turns (type, byte offset, rt value) into the
// bus size code, byte strobes, lane-replicated write data and a misalignment flag.
module store_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  mem_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [1:0]  size,
  output logic        misaligned
);

  // Strobe and data replication per access size; the slave picks lanes by wstrb.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    size       = size_of(mem_type);
    misaligned = is_misaligned(size, addr_lo);
    wstrb      = 4'b0000;
    wdata      = 32'h0;
    case (size)
      SZ_BYTE: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = data;
      end
    endcase
  end

endmodule

// File: rtl/mem_store_unit.sv
// MEM-stage store issuer. Checks alignment, latches the bus fields on
// acceptance, drives one write on the sram-like data bus and holds the pipe
// until data_ok. Misaligned stores raise AdES instead of touching the bus.
// Only WIDTH = 32 is supported.
module mem_store_unit
  import mem_access_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              store_valid,
  input  logic [1:0]        MemWriteTypeM,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [WIDTH-1:0]  store_data,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [WIDTH-1:0]  data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  output logic              store_stall,
  output logic              store_done,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] exc_badvaddr
);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [3:0]        lane_wstrb;
  logic [WIDTH-1:0]  lane_wdata;
  logic [1:0]        lane_size;
  logic              misaligned;
  logic              accept;

  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [WIDTH-1:0]  wdata_q;

  store_align u_align (
    .mem_type   (MemWriteTypeM),
    .addr_lo    (store_addr[1:0]),
    .data       (store_data),
    .wstrb      (lane_wstrb),
    .wdata      (lane_wdata),
    .size       (lane_size),
    .misaligned (misaligned)
  );

  // A store is taken only from IDLE, aligned and not being flushed.
  assign accept = (state == ST_IDLE) & store_valid & ~misaligned & ~flush;

  // Next-state logic. data_ok is only looked at in REQ and WAIT, so a stray or
  // unknown data_ok while idle or retiring has no effect.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_REQ;
      ST_REQ: begin
        if (data_addr_ok) state_next = data_data_ok ? ST_DONE : ST_WAIT;
        else if (flush)   state_next = ST_IDLE;
      end
      // Once the slave has the address the write is committed; flush cannot cancel it.
      ST_WAIT: if (data_data_ok) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset abandons any outstanding bus write.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Bus fields are captured once at acceptance and held stable through REQ/WAIT.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: these are a handful of datapath flops, so they are reset to give clean zero outputs.
    if (!resetn) begin
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wstrb_q <= 4'b0000;
      wdata_q <= '0;
    end else if (accept) begin
      size_q  <= lane_size;
      addr_q  <= store_addr;
      wstrb_q <= lane_wstrb;
      wdata_q <= lane_wdata;
    end
  end

  assign data_req   = (state == ST_REQ);
  assign data_wr    = data_req;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wstrb = wstrb_q;
  assign data_wdata = wdata_q;
  assign store_done = (state == ST_DONE);

  // Stall covers the accept cycle and the whole bus handshake, but not DONE so
  // the store retires exactly once. The resetn terms keep a store sitting on
  // the pipe from raising stall or AdES while reset is held.
  assign store_stall  = (state == ST_REQ) | (state == ST_WAIT) | (accept & resetn);
  assign exc_ades     = resetn & (state == ST_IDLE) & store_valid & misaligned & ~flush;
  assign exc_badvaddr = store_addr;

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit: lane building, bus handshake timing,
// AdES, flush in REQ/WAIT, async reset and back-to-back stores.
module tb_mem_store_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        store_valid;
  logic [1:0]  mem_type;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic        store_stall;
  logic        store_done;
  logic        exc_ades;
  logic [31:0] exc_badvaddr;

  int errors = 0;
  int checks = 0;
  int cycle_cnt = 0;

  mem_store_unit #(.WIDTH(32), .ADDR_W(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .store_valid   (store_valid),
    .MemWriteTypeM (mem_type),
    .store_addr    (store_addr),
    .store_data    (store_data),
    .flush         (flush),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wstrb    (data_wstrb),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .store_stall   (store_stall),
    .store_done    (store_done),
    .exc_ades      (exc_ades),
    .exc_badvaddr  (exc_badvaddr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Move to just after the next rising edge; all stimulus changes from here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one store and answer the bus with the given delays. Returns what
  // was observed; the calling test does the comparisons.
  task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                          input int ao_delay, input int do_delay,
                          output int accept_at, output int done_at,
                          output logic stall_ok, output logic stable_ok, output int req_cycles,
                          output logic [31:0] addr_seen, output logic [31:0] wdata_seen,
                          output logic [3:0] wstrb_seen, output logic [1:0] size_seen,
                          output logic timed_out);
    int   wait_cnt;
    logic in_wait;
    logic done_flag;
    store_valid  = 1'b1;
    mem_type     = t;
    store_addr   = a;
    store_data   = d;
    flush        = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    accept_at    = cycle_cnt;
    done_at      = -1;
    stall_ok     = 1'b1;
    stable_ok    = 1'b1;
    req_cycles   = 0;
    addr_seen    = '0;
    wdata_seen   = '0;
    wstrb_seen   = '0;
    size_seen    = '0;
    wait_cnt     = 0;
    in_wait      = 1'b0;
    done_flag    = 1'b0;
    for (int c = 0; c < 40 && !done_flag; c++) begin
      @(negedge clk);
      if (store_done) begin
        done_at   = cycle_cnt;
        done_flag = 1'b1;
      end else if (!store_stall) begin
        stall_ok = 1'b0;
      end
      if (data_req) begin
        if (req_cycles == 0) begin
          addr_seen  = data_addr;
          wdata_seen = data_wdata;
          wstrb_seen = data_wstrb;
          size_seen  = data_size;
        end else if (addr_seen !== data_addr || wdata_seen !== data_wdata ||
                     wstrb_seen !== data_wstrb || size_seen !== data_size) begin
          stable_ok = 1'b0;
        end
        req_cycles++;
        if (req_cycles > ao_delay) begin
          data_addr_ok = 1'b1;
          if (do_delay == 0) data_data_ok = 1'b1;
          else               in_wait = 1'b1;
        end
      end else if (in_wait) begin
        wait_cnt++;
        if (wait_cnt == do_delay) data_data_ok = 1'b1;
      end
      step();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (done_flag) store_valid = 1'b0;
    end
    timed_out   = !done_flag;
    store_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    store_valid = 1'b1; mem_type = 2'b10; store_addr = 32'h0000_0100; store_data = 32'hFFFF_FFFF;
    flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #12;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", data_req); end
    checks++; if (data_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", data_addr); end
    checks++; if ({data_size, data_wstrb} !== 6'h0) begin errors++; $display("FAIL reset_size_strb: got %h expected 0", {data_size, data_wstrb}); end
    checks++; if (data_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", data_wdata); end
    checks++; if ({store_done, store_stall} !== 2'b00) begin errors++; $display("FAIL reset_done_stall: got %b expected 00", {store_done, store_stall}); end
    store_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    step();
    // A stray data_ok while idle must not retire anything.
    data_data_ok = 1'b1;
    @(negedge clk);
    step();
    data_data_ok = 1'b0;
    @(negedge clk);
    checks++; if ({store_done, data_req} !== 2'b00) begin errors++; $display("FAIL idle_stray_data_ok: got %b expected 00", {store_done, data_req}); end
    step();
  endtask

  task automatic test_sb_fast();
    int acc, dn, rq; logic st, sb, to; logic [31:0] ad, wd; logic [3:0] ws; logic [1:0] sz;
    do_store(2'b00, 32'h0000_1003, 32'h0000_00A5, 0, 0, acc, dn, st, sb, rq, ad, wd, ws, sz, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL sb_timeout: got %b expected 0", to); end
    checks++; if (ws !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b expected 1000", ws); end
    checks++; if (wd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", wd); end
    checks++; if (sz !== 2'd0) begin errors++; $display("FAIL sb_size: got %0d expected 0", sz); end
    checks++; if (ad !== 32'h0000_1003) begin errors++; $display("FAIL sb_addr: got %h expected 00001003", ad); end
    checks++; if (dn - acc !== 2) begin errors++; $display("FAIL sb_latency: got %0d expected 2", dn - acc); end
    checks++; if ({st, rq} !== {1'b1, 32'sd1}) begin errors++; $display("FAIL sb_stall_req: got stall_ok=%b req=%0d expected 1/1", st, rq); end
  endtask

  task automatic test_sh_slow();
    int acc, dn, rq; logic st, sb, to; logic [31:0] ad, wd; logic [3:0] ws; logic [1:0] sz;
    do_store(2'b01, 32'h0000_2002, 32'h1234_BEEF, 2, 3, acc, dn, st, sb, rq, ad, wd, ws, sz, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL sh_timeout: got %b expected 0", to); end
    checks++; if (ws !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b expected 1100", ws); end
    checks++; if (wd !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h expected beefbeef", wd); end
    checks++; if (sz !== 2'd1) begin errors++; $display("FAIL sh_size: got %0d expected 1", sz); end
    checks++; if (dn - acc !== 7) begin errors++; $display("FAIL sh_latency: got %0d expected 7", dn - acc); end
    checks++; if (rq !== 3) begin errors++; $display("FAIL sh_req_cycles: got %0d expected 3", rq); end
    checks++; if ({st, sb} !== 2'b11) begin errors++; $display("FAIL sh_stall_stable: got %b expected 11", {st, sb}); end
    @(negedge clk);
    checks++; if (store_done !== 1'b0) begin errors++; $display("FAIL sh_single_done: got %b expected 0", store_done); end
    step();
  endtask

  task automatic test_lanes();
    logic [1:0]  t_tab [3] = '{2'b00, 2'b01, 2'b11};
    logic [31:0] a_tab [3] = '{32'h0000_1001, 32'h0000_2000, 32'h0000_2008};
    logic [31:0] d_tab [3] = '{32'h0000_0077, 32'hAAAA_5566, 32'h0102_0304};
    logic [3:0]  s_tab [3] = '{4'b0010, 4'b0011, 4'b1111};
    logic [31:0] w_tab [3] = '{32'h7777_7777, 32'h5566_5566, 32'h0102_0304};
    logic [1:0]  z_tab [3] = '{2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 3; i++) begin
      int acc, dn, rq; logic st, sb, to; logic [31:0] ad, wd; logic [3:0] ws; logic [1:0] sz;
      do_store(t_tab[i], a_tab[i], d_tab[i], 0, 0, acc, dn, st, sb, rq, ad, wd, ws, sz, to);
      checks++;
      if (to !== 1'b0 || ws !== s_tab[i] || wd !== w_tab[i] || sz !== z_tab[i]) begin
        errors++;
        $display("FAIL lanes[%0d]: got to=%b strb=%b data=%h size=%0d expected 0/%b/%h/%0d",
                 i, to, ws, wd, sz, s_tab[i], w_tab[i], z_tab[i]);
      end
    end
  endtask

  task automatic test_ades();
    logic [1:0]  t_tab [2] = '{2'b10, 2'b01};
    logic [31:0] a_tab [2] = '{32'h0000_3001, 32'h0000_3003};
    for (int i = 0; i < 2; i++) begin
      logic any_req, any_stall;
      store_valid = 1'b1; mem_type = t_tab[i]; store_addr = a_tab[i]; store_data = 32'h5555_AAAA; flush = 1'b0;
      #1;
      checks++; if (exc_ades !== 1'b1) begin errors++; $display("FAIL ades[%0d]: got %b expected 1", i, exc_ades); end
      checks++; if (exc_badvaddr !== a_tab[i]) begin errors++; $display("FAIL badvaddr[%0d]: got %h expected %h", i, exc_badvaddr, a_tab[i]); end
      any_req = 1'b0; any_stall = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        any_req   = any_req | data_req;
        any_stall = any_stall | store_stall;
        step();
      end
      checks++; if ({any_req, any_stall} !== 2'b00) begin errors++; $display("FAIL ades_quiet[%0d]: got req/stall=%b expected 00", i, {any_req, any_stall}); end
    end
    flush = 1'b1;
    #1;
    checks++; if (exc_ades !== 1'b0) begin errors++; $display("FAIL ades_flushed: got %b expected 0", exc_ades); end
    flush = 1'b0; store_valid = 1'b0;
    step();
  endtask

  task automatic test_flush_req();
    logic any_done;
    store_valid = 1'b1; mem_type = 2'b10; store_addr = 32'h0000_4000; store_data = 32'h0BAD_F00D; flush = 1'b0;
    @(negedge clk);
    checks++; if ({store_stall, data_req} !== 2'b10) begin errors++; $display("FAIL flush_accept: got stall/req=%b expected 10", {store_stall, data_req}); end
    step();
    flush = 1'b1;
    @(negedge clk);
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL flush_in_req: got %b expected 1", data_req); end
    step();
    flush = 1'b0; store_valid = 1'b0;
    @(negedge clk);
    checks++; if ({data_req, store_stall} !== 2'b00) begin errors++; $display("FAIL flush_dropped: got req/stall=%b expected 00", {data_req, store_stall}); end
    any_done = store_done;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      any_done = any_done | store_done;
    end
    checks++; if (any_done !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b expected 0", any_done); end
    step();
  endtask

  task automatic test_wait_flush_and_reset();
    // Flush during WAIT is ignored.
    store_valid = 1'b1; mem_type = 2'b10; store_addr = 32'h0000_5000; store_data = 32'h1122_3344; flush = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    checks++; if ({data_req, store_stall, store_done} !== 3'b010) begin errors++; $display("FAIL wait_flush: got req/stall/done=%b expected 010", {data_req, store_stall, store_done}); end
    step();
    flush = 1'b0;
    @(negedge clk);
    checks++; if ({store_stall, store_done} !== 2'b10) begin errors++; $display("FAIL wait_hold: got stall/done=%b expected 10", {store_stall, store_done}); end
    data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    @(negedge clk);
    checks++; if ({store_done, store_stall} !== 2'b10) begin errors++; $display("FAIL wait_done: got done/stall=%b expected 10", {store_done, store_stall}); end
    step();
    store_valid = 1'b0;
    @(negedge clk);
    checks++; if (store_done !== 1'b0) begin errors++; $display("FAIL wait_done_once: got %b expected 0", store_done); end
    step();
    // Async reset while in WAIT.
    store_valid = 1'b1; mem_type = 2'b10; store_addr = 32'h0000_5004; store_data = 32'hCAFE_F00D;
    @(negedge clk);
    step();
    @(negedge clk);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    @(negedge clk);
    checks++; if ({data_addr, store_stall} !== {32'h0000_5004, 1'b1}) begin errors++; $display("FAIL rst_pre: got addr=%h stall=%b expected 00005004/1", data_addr, store_stall); end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({data_req, data_wr, data_size, data_wstrb, store_done, store_stall, exc_ades} !== 11'h0 ||
        data_addr !== 32'h0 || data_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: got req=%b wr=%b size=%0d addr=%h strb=%b wdata=%h done=%b stall=%b expected all 0",
               data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, store_done, store_stall);
    end
    store_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    step();
    data_data_ok = 1'b1;
    @(negedge clk);
    step();
    data_data_ok = 1'b0;
    @(negedge clk);
    checks++; if ({store_done, data_req} !== 2'b00) begin errors++; $display("FAIL rst_abandon: got done/req=%b expected 00", {store_done, data_req}); end
    step();
  endtask

  task automatic test_back_to_back();
    int acc1, dn1, rq1, acc2, dn2, rq2; logic st1, sb1, to1, st2, sb2, to2;
    logic [31:0] ad1, wd1, ad2, wd2; logic [3:0] ws1, ws2; logic [1:0] sz1, sz2;
    do_store(2'b00, 32'h0000_0010, 32'h0000_005A, 0, 0, acc1, dn1, st1, sb1, rq1, ad1, wd1, ws1, sz1, to1);
    do_store(2'b10, 32'h0000_0014, 32'hDEAD_BEEF, 0, 0, acc2, dn2, st2, sb2, rq2, ad2, wd2, ws2, sz2, to2);
    checks++; if ({to1, to2} !== 2'b00) begin errors++; $display("FAIL b2b_timeout: got %b expected 00", {to1, to2}); end
    checks++; if (ad1 !== 32'h0000_0010 || ws1 !== 4'b0001 || wd1 !== 32'h5A5A_5A5A) begin errors++; $display("FAIL b2b_first: got %h/%b/%h expected 00000010/0001/5a5a5a5a", ad1, ws1, wd1); end
    checks++; if (ad2 !== 32'h0000_0014 || ws2 !== 4'b1111 || wd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_second: got %h/%b/%h expected 00000014/1111/deadbeef", ad2, ws2, wd2); end
    checks++; if (dn2 - dn1 !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d expected 3", dn2 - dn1); end
  endtask

  initial begin
    test_reset();
    test_sb_fast();
    test_sh_slow();
    test_lanes();
    test_ades();
    test_flush_req();
    test_wait_flush_and_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
